// File: rtl/vector_sequencer.sv
// Point-list controller for the vector display: queues beam points, loads each into the line
// stepper, then paces the stepper one step per completed DAC write.
module vector_sequencer #(
   parameter int unsigned ADDR_BITS = 4,
   parameter int unsigned SETTLE    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pt_valid,
   output logic                 pt_ready,
   input  logic [11:0]          pt_x,
   input  logic [11:0]          pt_y,
   input  logic                 pt_blank,
   output logic                 lt_strobe,
   output logic                 lt_next,
   output logic [11:0]          lt_x,
   output logic [11:0]          lt_y,
   input  logic                 lt_ready,
   input  logic                 lt_axis,
   input  logic [11:0]          lt_x_out,
   input  logic [11:0]          lt_y_out,
   output logic                 dac_strobe,
   output logic                 dac_axis,
   output logic [11:0]          dac_value,
   input  logic                 dac_ready,
   output logic                 blank,
   output logic                 busy,
   output logic [ADDR_BITS:0]   fifo_count
);

   localparam int unsigned DEPTH = 2 ** ADDR_BITS;
   localparam int unsigned CW    = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

   localparam logic [ADDR_BITS:0]   FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);
   localparam logic [ADDR_BITS:0]   CNT_ONE    = (ADDR_BITS + 1)'(1);
   localparam logic [ADDR_BITS-1:0] PTR_ONE    = ADDR_BITS'(1);
   localparam logic [CW-1:0]        SETTLE_CNT = CW'(SETTLE);
   localparam logic [CW-1:0]        SETTLE_ONE = CW'(1);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StDwell,
      StStep,
      StWrite,
      StWait
   } state_t;

   logic [24:0]          r_mem [DEPTH];
   logic [ADDR_BITS-1:0] r_wr_ptr;
   logic [ADDR_BITS-1:0] r_rd_ptr;
   logic [ADDR_BITS:0]   r_count;

   state_t               r_state;
   logic                 r_pend_blank;
   logic                 r_blank;
   logic [11:0]          r_lt_x;
   logic [11:0]          r_lt_y;
   logic [CW-1:0]        r_settle_cnt;

   logic                 w_full;
   logic                 w_push;
   logic                 w_pop;
   logic [24:0]          w_head;

   assign w_full   = (r_count == FULL_COUNT);
   assign pt_ready = !w_full && !reset;
   assign w_push   = pt_valid && pt_ready;
   assign w_pop    = (r_state == StIdle) && (r_count != '0);
   assign w_head   = r_mem[r_rd_ptr];

   // Storage needs no reset: only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {pt_blank, pt_x, pt_y};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= StIdle;
         r_pend_blank <= 1'b1;
         r_blank      <= 1'b1;
         r_lt_x       <= '0;
         r_lt_y       <= '0;
         r_settle_cnt <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (r_count != '0) begin
                  {r_pend_blank, r_lt_x, r_lt_y} <= w_head;
                  r_state                        <= StLoad;
               end
            end
            StLoad: begin
               r_blank <= r_pend_blank;
               // Beam needs time to settle only when the blank level actually toggles.
               if ((r_pend_blank != r_blank) && (SETTLE > 0)) begin
                  r_settle_cnt <= SETTLE_CNT;
                  r_state      <= StDwell;
               end else begin
                  r_state <= StStep;
               end
            end
            StDwell: begin
               if (r_settle_cnt <= SETTLE_ONE) begin
                  r_state <= StStep;
               end else begin
                  r_settle_cnt <= r_settle_cnt - SETTLE_ONE;
               end
            end
            StStep: begin
               r_state <= lt_ready ? StIdle : StWrite;
            end
            StWrite: begin
               if (dac_ready) begin
                  r_state <= StWait;
               end
            end
            StWait: begin
               if (dac_ready) begin
                  r_state <= StStep;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign lt_strobe  = (r_state == StLoad);
   assign lt_next    = (r_state == StStep) && !lt_ready;
   assign lt_x       = r_lt_x;
   assign lt_y       = r_lt_y;
   assign dac_strobe = (r_state == StWrite) && dac_ready;
   assign dac_axis   = lt_axis;
   assign dac_value  = lt_axis ? lt_y_out : lt_x_out;
   assign blank      = r_blank;
   assign busy       = (r_state != StIdle) || (r_count != '0);
   assign fifo_count = r_count;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer with a simple one-axis-at-a-time stepper model and a
// DAC model that stays busy 32 cycles after each strobe.
module tb_vector_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pt_valid = 1'b0;
   logic        pt_ready;
   logic [11:0] pt_x = '0;
   logic [11:0] pt_y = '0;
   logic        pt_blank = 1'b0;
   logic        lt_strobe, lt_next;
   logic [11:0] lt_x, lt_y;
   logic        lt_ready, lt_axis;
   logic [11:0] lt_x_out, lt_y_out;
   logic        dac_strobe, dac_axis;
   logic [11:0] dac_value;
   logic        dac_ready;
   logic        blank, busy;
   logic [4:0]  fifo_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   vector_sequencer #(.ADDR_BITS(4), .SETTLE(8)) dut (
      .clk(clk), .reset(reset),
      .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y), .pt_blank(pt_blank),
      .lt_strobe(lt_strobe), .lt_next(lt_next), .lt_x(lt_x), .lt_y(lt_y),
      .lt_ready(lt_ready), .lt_axis(lt_axis), .lt_x_out(lt_x_out), .lt_y_out(lt_y_out),
      .dac_strobe(dac_strobe), .dac_axis(dac_axis), .dac_value(dac_value),
      .dac_ready(dac_ready), .blank(blank), .busy(busy), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stepper model: moves x to target first, then y, one unit per lt_next.
   logic [11:0] s_x, s_y, s_dx, s_dy;
   logic        s_axis;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         s_x <= '0; s_y <= '0; s_dx <= '0; s_dy <= '0; s_axis <= 1'b0;
      end else if (lt_strobe) begin
         s_dx <= lt_x; s_dy <= lt_y;
      end else if (lt_next) begin
         if (s_x != s_dx) begin
            s_x    <= (s_dx > s_x) ? s_x + 12'd1 : s_x - 12'd1;
            s_axis <= 1'b0;
         end else if (s_y != s_dy) begin
            s_y    <= (s_dy > s_y) ? s_y + 12'd1 : s_y - 12'd1;
            s_axis <= 1'b1;
         end
      end
   end
   assign lt_ready = (s_x == s_dx) && (s_y == s_dy);
   assign lt_axis  = s_axis;
   assign lt_x_out = s_x;
   assign lt_y_out = s_y;

   int dac_cnt;
   always @(posedge clk or posedge reset) begin
      if (reset)           dac_cnt <= 0;
      else if (dac_strobe) dac_cnt <= 32;
      else if (dac_cnt != 0) dac_cnt <= dac_cnt - 1;
   end
   assign dac_ready = (dac_cnt == 0);

   // Event logs, sampled on the falling edge.
   int          dac_cyc_q[$];
   logic [12:0] dac_av_q[$];
   int          ls_cyc_q[$];
   logic [23:0] ls_xy_q[$];
   int          ln_cyc_q[$];
   int          bl_cyc_q[$];
   logic        blank_prev = 1'b1;
   always @(negedge clk) begin
      if (dac_strobe === 1'b1) begin
         dac_cyc_q.push_back(cyc);
         dac_av_q.push_back({dac_axis, dac_value});
      end
      if (lt_strobe === 1'b1) begin
         ls_cyc_q.push_back(cyc);
         ls_xy_q.push_back({lt_x, lt_y});
      end
      if (lt_next === 1'b1) ln_cyc_q.push_back(cyc);
      if (blank !== blank_prev) bl_cyc_q.push_back(cyc);
      blank_prev <= blank;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Offers a point from the current falling edge until accepted; leaves pt_valid high.
   task automatic push_wait(input logic [11:0] x, input logic [11:0] y, input logic b,
                            output int acc);
      pt_x = x; pt_y = y; pt_blank = b; pt_valid = 1'b1;
      acc = -1;
      for (int n = 0; n < 3000; n++) begin
         if (pt_ready) begin
            acc = cyc;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic wait_idle(output int idle_cyc);
      idle_cyc = -1;
      for (int n = 0; n < 5000; n++) begin
         if (!busy) begin
            idle_cyc = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      int b_d, b_s, b_n;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (pt_ready !== 1'b0) begin errors++;
         $display("FAIL rst_pt_ready_held: got %b expected 0", pt_ready); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (blank !== 1'b1) begin errors++;
         $display("FAIL rst_blank: got %b expected 1", blank); end
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (fifo_count !== 5'd0) begin errors++;
         $display("FAIL rst_count: got %0d expected 0", fifo_count); end
      checks++; if (pt_ready !== 1'b1) begin errors++;
         $display("FAIL rst_pt_ready: got %b expected 1", pt_ready); end
      checks++; if ({lt_x, lt_y} !== 24'd0) begin errors++;
         $display("FAIL rst_lt_xy: got %h expected 0", {lt_x, lt_y}); end
      b_d = dac_cyc_q.size(); b_s = ls_cyc_q.size(); b_n = ln_cyc_q.size();
      repeat (100) @(negedge clk);
      checks++; if (dac_cyc_q.size() + ls_cyc_q.size() + ln_cyc_q.size() != b_d + b_s + b_n)
         begin errors++;
         $display("FAIL rst_no_strobes: got %0d strobes expected 0",
                  dac_cyc_q.size() + ls_cyc_q.size() + ln_cyc_q.size() - b_d - b_s - b_n); end
   endtask

   task automatic test_line();
      int b_d, b_s, b_n, b_b, acc, idle, l;
      logic [12:0] exp [4];
      exp = '{{1'b0, 12'd1}, {1'b0, 12'd2}, {1'b0, 12'd3}, {1'b1, 12'd1}};
      b_d = dac_cyc_q.size(); b_s = ls_cyc_q.size(); b_n = ln_cyc_q.size(); b_b = bl_cyc_q.size();
      push_wait(12'd3, 12'd1, 1'b0, acc);
      pt_valid = 1'b0;
      wait_idle(idle);
      l = acc + 2;
      checks++; if (acc < 0 || idle < 0) begin errors++;
         $display("FAIL line_timeout: acc %0d idle %0d expected both >= 0", acc, idle); end
      checks++; if (ls_cyc_q.size() != b_s + 1 || ls_cyc_q[b_s] != l) begin errors++;
         $display("FAIL line_load_cycle: got %0d expected %0d", ls_cyc_q[b_s], l); end
      checks++; if (bl_cyc_q.size() != b_b + 1 || bl_cyc_q[b_b] != l + 1 || blank !== 1'b0)
         begin errors++;
         $display("FAIL line_blank_fall: got %0d/%b expected %0d/0", bl_cyc_q[b_b], blank, l + 1);
      end
      checks++; if (ln_cyc_q.size() != b_n + 4 || ln_cyc_q[b_n] != l + 9) begin errors++;
         $display("FAIL line_first_next: got %0d expected %0d", ln_cyc_q[b_n], l + 9); end
      checks++; if (dac_cyc_q.size() != b_d + 4) begin errors++;
         $display("FAIL line_write_count: got %0d expected 4", dac_cyc_q.size() - b_d); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (dac_av_q[b_d+i] !== exp[i] || dac_cyc_q[b_d+i] != l + 10 + 35 * i) begin
               errors++;
               $display("FAIL line_write%0d: got %h@%0d expected %h@%0d", i, dac_av_q[b_d+i],
                        dac_cyc_q[b_d+i], exp[i], l + 10 + 35 * i);
            end
         end
      end
      checks++; if (idle != l + 150) begin errors++;
         $display("FAIL line_idle_cycle: got %0d expected %0d", idle, l + 150); end
   endtask

   task automatic test_duplicate();
      int b_d, b_s, b_n, b_b, acc, idle;
      b_d = dac_cyc_q.size(); b_s = ls_cyc_q.size(); b_n = ln_cyc_q.size(); b_b = bl_cyc_q.size();
      push_wait(12'd3, 12'd1, 1'b0, acc);
      pt_valid = 1'b0;
      wait_idle(idle);
      checks++; if (ls_cyc_q.size() != b_s + 1 || ls_cyc_q[b_s] != acc + 2) begin errors++;
         $display("FAIL dup_load: got %0d loads expected 1 at %0d", ls_cyc_q.size() - b_s, acc + 2);
      end
      checks++; if (dac_cyc_q.size() != b_d || ln_cyc_q.size() != b_n) begin errors++;
         $display("FAIL dup_no_steps: got %0d writes %0d nexts expected 0 0",
                  dac_cyc_q.size() - b_d, ln_cyc_q.size() - b_n); end
      checks++; if (bl_cyc_q.size() != b_b || blank !== 1'b0) begin errors++;
         $display("FAIL dup_blank: got %b expected 0 unchanged", blank); end
      checks++; if (idle != acc + 4) begin errors++;
         $display("FAIL dup_idle_cycle: got %0d expected %0d", idle, acc + 4); end
   endtask

   task automatic test_blank_edge();
      int b_d, b_s, b_n, b_b, acc, idle, l;
      logic [12:0] exp [4];
      exp = '{{1'b0, 12'd2}, {1'b0, 12'd1}, {1'b0, 12'd0}, {1'b1, 12'd0}};
      b_d = dac_cyc_q.size(); b_s = ls_cyc_q.size(); b_n = ln_cyc_q.size(); b_b = bl_cyc_q.size();
      push_wait(12'd0, 12'd0, 1'b1, acc);
      pt_valid = 1'b0;
      wait_idle(idle);
      l = acc + 2;
      checks++; if (bl_cyc_q.size() != b_b + 1 || bl_cyc_q[b_b] != l + 1 || blank !== 1'b1)
         begin errors++;
         $display("FAIL edge_blank_rise: got %0d/%b expected %0d/1", bl_cyc_q[b_b], blank, l + 1);
      end
      checks++; if (ln_cyc_q.size() != b_n + 4 || ln_cyc_q[b_n] != l + 9) begin errors++;
         $display("FAIL edge_dwell: first next %0d expected %0d", ln_cyc_q[b_n], l + 9); end
      checks++; if (dac_cyc_q.size() != b_d + 4) begin errors++;
         $display("FAIL edge_write_count: got %0d expected 4", dac_cyc_q.size() - b_d); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (dac_av_q[b_d+i] !== exp[i] || dac_cyc_q[b_d+i] != l + 10 + 35 * i) begin
               errors++;
               $display("FAIL edge_write%0d: got %h@%0d expected %h@%0d", i, dac_av_q[b_d+i],
                        dac_cyc_q[b_d+i], exp[i], l + 10 + 35 * i);
            end
         end
      end
      checks++; if (ls_cyc_q.size() != b_s + 1 || idle < 0) begin errors++;
         $display("FAIL edge_done: loads %0d idle %0d expected 1 and >=0",
                  ls_cyc_q.size() - b_s, idle); end
   endtask

   task automatic test_back_to_back();
      int b_d, b_s, acc, acc1, acc17, idle;
      b_d = dac_cyc_q.size(); b_s = ls_cyc_q.size();
      push_wait(12'd20, 12'd0, 1'b1, acc);
      pt_valid = 1'b0;
      repeat (3) @(negedge clk);
      acc1 = -1;
      for (int k = 1; k <= 16; k++) begin
         push_wait(12'd20, 12'(k), 1'b1, acc);
         if (k == 1) acc1 = acc;
         else begin
            checks++; if (acc != acc1 + k - 1) begin errors++;
               $display("FAIL b2b_accept%0d: got %0d expected %0d", k, acc, acc1 + k - 1); end
         end
      end
      checks++; if (fifo_count !== 5'd16 || pt_ready !== 1'b0) begin errors++;
         $display("FAIL b2b_full: got count %0d ready %b expected 16 0", fifo_count, pt_ready); end
      push_wait(12'd20, 12'd17, 1'b1, acc17);
      pt_valid = 1'b0;
      wait_idle(idle);
      checks++; if (ls_cyc_q.size() != b_s + 18) begin errors++;
         $display("FAIL b2b_load_count: got %0d expected 18", ls_cyc_q.size() - b_s); end
      else begin
         checks++; if (acc17 != ls_cyc_q[b_s+1]) begin errors++;
            $display("FAIL b2b_17th_accept: got %0d expected %0d", acc17, ls_cyc_q[b_s+1]); end
         for (int k = 0; k <= 17; k++) begin
            checks++;
            if (ls_xy_q[b_s+k] !== {12'd20, 12'(k)}) begin errors++;
               $display("FAIL b2b_order%0d: got %h expected %h", k, ls_xy_q[b_s+k],
                        {12'd20, 12'(k)}); end
         end
      end
      checks++; if (dac_cyc_q.size() != b_d + 37 || dac_av_q[dac_av_q.size()-1] !== 13'h1011)
         begin errors++;
         $display("FAIL b2b_writes: got %0d last %h expected 37 last 1011",
                  dac_cyc_q.size() - b_d, dac_av_q[dac_av_q.size()-1]); end
   endtask

   task automatic test_reset_mid();
      int b_d, b_s, b_n, acc, n;
      b_d = dac_cyc_q.size();
      push_wait(12'd0, 12'd17, 1'b0, acc);
      for (int k = 1; k <= 5; k++) push_wait(12'(k), 12'd17, 1'b0, acc);
      pt_valid = 1'b0;
      n = 0;
      while (dac_cyc_q.size() == b_d && n < 500) begin @(negedge clk); n++; end
      repeat (5) @(negedge clk);
      checks++; if (fifo_count !== 5'd5 || blank !== 1'b0 || n >= 500) begin errors++;
         $display("FAIL mid_setup: count %0d blank %b wait %0d expected 5 0 <500",
                  fifo_count, blank, n); end
      reset = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || fifo_count !== 5'd0) begin errors++;
         $display("FAIL mid_flush: busy %b count %0d expected 0 0", busy, fifo_count); end
      checks++; if (blank !== 1'b1 || pt_ready !== 1'b0) begin errors++;
         $display("FAIL mid_blank: blank %b ready %b expected 1 0", blank, pt_ready); end
      checks++; if ({lt_x, lt_y} !== 24'd0) begin errors++;
         $display("FAIL mid_lt_xy: got %h expected 0", {lt_x, lt_y}); end
      reset = 1'b0;
      b_d = dac_cyc_q.size(); b_s = ls_cyc_q.size(); b_n = ln_cyc_q.size();
      repeat (100) @(negedge clk);
      checks++; if (dac_cyc_q.size() != b_d || ls_cyc_q.size() != b_s || ln_cyc_q.size() != b_n)
         begin errors++;
         $display("FAIL mid_no_strobes: got %0d %0d %0d expected 0 0 0", dac_cyc_q.size() - b_d,
                  ls_cyc_q.size() - b_s, ln_cyc_q.size() - b_n); end
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL mid_idle: got busy %b expected 0", busy); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_line();
      test_duplicate();
      test_blank_edge();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
